aes_round_sequencer: RTL and testbench

- Parametrised next-generation AES-core controller. Sequences key load, key expansion, data load, the per-round stage pipeline (sub bytes, shift rows, mix columns, add round key) and result write-back.
- Supports 128/192/256-bit key modes, multi-block jobs under one key, and a per-stage watchdog.
- Sits between the AHB slave interface logic and the AES datapath stage blocks. Drives HREADYOUT back to the bus.

---
 rtl/aes_round_sequencer.sv | 262 ++++++++++++++++++++++++++
 tb/tb_aes_round_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer
//   Control FSM for an AES core. Sequences key load, key expansion, data
//   load, the per-round stage pipeline (sub bytes, shift rows, mix columns,
//   add round key) and result write-back for NUM_BLOCKS blocks per job under
//   one key. A per-stage watchdog forces ERROR when a stage stalls.
//
//   Optional macro AES_DECRYPT_EN: adds the decrypt input (inverse round
//   order, round_num counting down) and holds write_enable off until m_read.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   addr_match, hsel,   bus request qualifiers; a job starts on
//   m_write             hsel & addr_match & m_write while idle/error
//   m_read              read handshake for write-back (decrypt build only)
//   data_ready          key/data word load complete
//   key_mode[1:0]       00=AES-128, 01=AES-192, 10=AES-256, 11=illegal
//   *_finished          stage done strobes
//   HREADYOUT           low while a job is in progress
//   *_enable            stage enables (Moore decodes of state)
//   round_num[3:0]      current round
//   block_num[7:0]      current block index
//   error               high while in the error state
module aes_round_sequencer #(
    parameter int NUM_BLOCKS     = 1,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TIMEOUT_W      = 9
) (
    input  logic       clk,
    input  logic       rst,
`ifdef AES_DECRYPT_EN
    input  logic       decrypt,
`endif
    input  logic       addr_match,
    input  logic       hsel,
    input  logic       m_write,
    input  logic       m_read,
    input  logic       data_ready,
    input  logic [1:0] key_mode,
    input  logic       keyexp_finished,
    input  logic       sbytes_finished,
    input  logic       srows_finished,
    input  logic       mcol_finished,
    input  logic       around_finished,
    input  logic       write_finished,
    output logic       HREADYOUT,
    output logic       readk_enable,
    output logic       keyexp_enable,
    output logic       read_enable,
    output logic       sbytes_enable,
    output logic       srows_enable,
    output logic       mcol_enable,
    output logic       around_enable,
    output logic       write_enable,
    output logic [3:0] round_num,
    output logic [7:0] block_num,
    output logic       error
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_READ_KEY,
        S_KEY_EXP,
        S_READ_DATA,
        S_INIT_ARK,
        S_SUB_BYTES,
        S_SHIFT_ROWS,
        S_MIX_COL,
        S_ADD_RK,
        S_WRITE_OUT,
        S_ERROR
    } state_t;

    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]           BLK_LAST = 8'(NUM_BLOCKS - 1);

    state_t               state_q, state_d;
    logic [3:0]           round_q, round_d;
    logic [7:0]           block_q, block_d;
    logic [1:0]           mode_q, mode_d;
    logic [TIMEOUT_W-1:0] wd_q, wd_d;
    logic                 in_stage;
    logic                 bus_wr;
    logic [3:0]           nr;
    logic                 dec;
    logic                 wr_ok;

`ifdef AES_DECRYPT_EN
    logic dec_q, dec_d;
    logic rd_seen_q, rd_seen_d;

    assign dec   = dec_q;
    assign wr_ok = rd_seen_q;
    // m_read must be seen while already in WRITE_OUT before write_enable rises
    assign rd_seen_d = (state_q == S_WRITE_OUT) && (state_d == S_WRITE_OUT) &&
                       (rd_seen_q || m_read);

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_q     <= 1'b0;
            rd_seen_q <= 1'b0;
        end else begin
            dec_q     <= dec_d;
            rd_seen_q <= rd_seen_d;
        end
    end
`else
    logic unused_m_read;

    assign dec           = 1'b0;
    assign wr_ok         = 1'b1;
    assign unused_m_read = m_read;
`endif

    assign bus_wr = hsel & addr_match & m_write;

    always_comb begin
        case (mode_q)
            2'b00:   nr = 4'd10;
            2'b01:   nr = 4'd12;
            default: nr = 4'd14;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        round_d  = round_q;
        block_d  = block_q;
        mode_d   = mode_q;
`ifdef AES_DECRYPT_EN
        dec_d    = dec_q;
`endif
        in_stage = 1'b1;

        case (state_q)
            S_IDLE, S_ERROR: begin
                in_stage = 1'b0;
                if (bus_wr) begin
                    if (key_mode == 2'b11) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_READ_KEY;
                        mode_d  = key_mode;
`ifdef AES_DECRYPT_EN
                        dec_d   = decrypt;
`endif
                    end
                end
            end
            S_READ_KEY: begin
                if (data_ready) state_d = S_KEY_EXP;
            end
            S_KEY_EXP: begin
                if (keyexp_finished) state_d = S_READ_DATA;
            end
            S_READ_DATA: begin
                if (data_ready) begin
                    state_d = S_INIT_ARK;
                    round_d = dec ? nr : 4'd0;
                end
            end
            S_INIT_ARK: begin
                if (around_finished) begin
                    if (dec) begin
                        state_d = S_SHIFT_ROWS;
                        round_d = round_q - 4'd1;
                    end else begin
                        state_d = S_SUB_BYTES;
                        round_d = 4'd1;
                    end
                end
            end
            S_SUB_BYTES: begin
                if (sbytes_finished) state_d = dec ? S_ADD_RK : S_SHIFT_ROWS;
            end
            S_SHIFT_ROWS: begin
                if (srows_finished) begin
                    if (dec)               state_d = S_SUB_BYTES;
                    else if (round_q < nr) state_d = S_MIX_COL;
                    else                   state_d = S_ADD_RK;
                end
            end
            S_MIX_COL: begin
                if (mcol_finished) begin
                    if (dec) begin
                        state_d = S_SHIFT_ROWS;
                        round_d = round_q - 4'd1;
                    end else begin
                        state_d = S_ADD_RK;
                    end
                end
            end
            S_ADD_RK: begin
                if (around_finished) begin
                    if (dec) begin
                        state_d = (round_q == 4'd0) ? S_WRITE_OUT : S_MIX_COL;
                    end else if (round_q < nr) begin
                        state_d = S_SUB_BYTES;
                        round_d = round_q + 4'd1;
                    end else begin
                        state_d = S_WRITE_OUT;
                    end
                end
            end
            S_WRITE_OUT: begin
                if (write_finished && wr_ok) begin
                    if (block_q < BLK_LAST) begin
                        state_d = S_READ_DATA;
                        block_d = block_q + 8'd1;
                    end else begin
                        state_d = S_IDLE;
                        block_d = '0;
                        round_d = '0;
                    end
                end
            end
            default: begin
                in_stage = 1'b0;
                state_d  = S_IDLE;
            end
        endcase

        // A done strobe on the last allowed cycle has already moved state_d,
        // so it takes priority over the timeout.
        if (in_stage && (state_d == state_q) && (wd_q == TMO_LAST)) begin
            state_d = S_ERROR;
            round_d = '0;
            block_d = '0;
        end

        wd_d = (in_stage && (state_d == state_q)) ? wd_q + 1'b1 : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            round_q <= '0;
            block_q <= '0;
            mode_q  <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            block_q <= block_d;
            mode_q  <= mode_d;
            wd_q    <= wd_d;
        end
    end

    assign HREADYOUT     = (state_q == S_IDLE) || (state_q == S_ERROR);
    assign readk_enable  = (state_q == S_READ_KEY);
    assign keyexp_enable = (state_q == S_KEY_EXP);
    assign read_enable   = (state_q == S_READ_DATA);
    assign sbytes_enable = (state_q == S_SUB_BYTES);
    assign srows_enable  = (state_q == S_SHIFT_ROWS);
    assign mcol_enable   = (state_q == S_MIX_COL);
    assign around_enable = (state_q == S_INIT_ARK) || (state_q == S_ADD_RK);
    assign write_enable  = (state_q == S_WRITE_OUT) && wr_ok;
    assign error         = (state_q == S_ERROR);
    assign round_num     = round_q;
    assign block_num     = block_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Testbench for aes_round_sequencer (default build, AES_DECRYPT_EN undefined).
// The reference is a queue of expected stage steps (stage, round, block)
// built per job from the round schedule; the bench returns each stage's done
// strobe after a chosen latency and retires the head step when it does.
module tb_aes_round_sequencer;

    localparam int NB  = 3;
    localparam int TMO = 256;

    localparam int K_RK = 0, K_KE = 1, K_RD = 2, K_IA = 3, K_SB = 4,
                   K_SR = 5, K_MC = 6, K_AR = 7, K_WR = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       addr_match, hsel, m_write, m_read, data_ready;
    logic [1:0] key_mode;
    logic       keyexp_finished, sbytes_finished, srows_finished;
    logic       mcol_finished, around_finished, write_finished;
    logic       HREADYOUT, readk_enable, keyexp_enable, read_enable;
    logic       sbytes_enable, srows_enable, mcol_enable, around_enable;
    logic       write_enable, error;
    logic [3:0] round_num;
    logic [7:0] block_num;

    always #5 clk = ~clk;

    aes_round_sequencer #(
        .NUM_BLOCKS    (NB),
        .TIMEOUT_CYCLES(TMO),
        .TIMEOUT_W     (9)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .addr_match     (addr_match),
        .hsel           (hsel),
        .m_write        (m_write),
        .m_read         (m_read),
        .data_ready     (data_ready),
        .key_mode       (key_mode),
        .keyexp_finished(keyexp_finished),
        .sbytes_finished(sbytes_finished),
        .srows_finished (srows_finished),
        .mcol_finished  (mcol_finished),
        .around_finished(around_finished),
        .write_finished (write_finished),
        .HREADYOUT      (HREADYOUT),
        .readk_enable   (readk_enable),
        .keyexp_enable  (keyexp_enable),
        .read_enable    (read_enable),
        .sbytes_enable  (sbytes_enable),
        .srows_enable   (srows_enable),
        .mcol_enable    (mcol_enable),
        .around_enable  (around_enable),
        .write_enable   (write_enable),
        .round_num      (round_num),
        .block_num      (block_num),
        .error          (error)
    );

    typedef struct {
        int kind;
        int rnd;
        int blk;
    } step_t;

    step_t q[$];
    bit    m_err;
    int    step_cyc;
    int    lat;
    int    lat_max;
    int    force_lat;
    bit    noise;
    int    checks;
    int    errors;
    int    cyc_no;

    // observed-activity counters (edges of DUT outputs)
    int cnt_mc, cnt_ar, cnt_ke, cnt_rd, cnt_wr, cnt_busy, cnt_sbh;
    logic p_mc, p_ar, p_ke, p_rd, p_wr;
    int rd_blk[$];

    function automatic int nr_of(input int km);
        return 10 + 2 * km;
    endfunction

    function automatic int pick_lat();
        return (force_lat >= 0) ? force_lat : int'($urandom_range(lat_max, 0));
    endfunction

    function automatic void build_job(input int nr);
        q.delete();
        q.push_back('{K_RK, 0, 0});
        q.push_back('{K_KE, 0, 0});
        for (int b = 0; b < NB; b++) begin
            q.push_back('{K_RD, (b == 0) ? 0 : nr, b});
            q.push_back('{K_IA, 0, b});
            for (int r = 1; r <= nr; r++) begin
                q.push_back('{K_SB, r, b});
                q.push_back('{K_SR, r, b});
                if (r < nr) q.push_back('{K_MC, r, b});
                q.push_back('{K_AR, r, b});
            end
            q.push_back('{K_WR, nr, b});
        end
    endfunction

    function automatic int done_idx(input int kind);
        case (kind)
            K_RK, K_RD: return 0;
            K_KE:       return 1;
            K_SB:       return 2;
            K_SR:       return 3;
            K_MC:       return 4;
            K_IA, K_AR: return 5;
            default:    return 6;
        endcase
    endfunction

    function automatic logic [21:0] exp_vec();
        logic [7:0] en;
        if (q.size() == 0) return {1'b1, 8'h00, m_err, 4'd0, 8'd0};
        case (q[0].kind)
            K_RK:       en = 8'b1000_0000;
            K_KE:       en = 8'b0100_0000;
            K_RD:       en = 8'b0010_0000;
            K_SB:       en = 8'b0001_0000;
            K_SR:       en = 8'b0000_1000;
            K_MC:       en = 8'b0000_0100;
            K_IA, K_AR: en = 8'b0000_0010;
            default:    en = 8'b0000_0001;
        endcase
        return {1'b0, en, 1'b0, 4'(q[0].rnd), 8'(q[0].blk)};
    endfunction

    function automatic logic [21:0] dut_vec();
        return {HREADYOUT, readk_enable, keyexp_enable, read_enable,
                sbytes_enable, srows_enable, mcol_enable, around_enable,
                write_enable, error, round_num, block_num};
    endfunction

    task automatic check_lit(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic clear_counts();
        cnt_mc = 0; cnt_ar = 0; cnt_ke = 0; cnt_rd = 0; cnt_wr = 0;
        cnt_busy = 0; cnt_sbh = 0;
        rd_blk.delete();
    endtask

    // One clock cycle: compare, drive inputs, advance the reference.
    task automatic cyc(input bit rst_in, input bit start, input logic [1:0] km);
        logic [6:0] dn;
        logic [21:0] e, g;
        bit busy, done_now;
        int hs;
        @(negedge clk);
        cyc_no++;
        e = exp_vec();
        g = dut_vec();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL outputs cycle %0d: got %h expected %h", cyc_no, g, e);
        end
        if (mcol_enable && !p_mc)   cnt_mc++;
        if (around_enable && !p_ar) cnt_ar++;
        if (keyexp_enable && !p_ke) cnt_ke++;
        if (read_enable && !p_rd) begin
            cnt_rd++;
            rd_blk.push_back(int'(block_num));
        end
        if (write_enable && !p_wr)  cnt_wr++;
        if (!HREADYOUT)             cnt_busy++;
        if (sbytes_enable)          cnt_sbh++;
        p_mc = mcol_enable; p_ar = around_enable; p_ke = keyexp_enable;
        p_rd = read_enable; p_wr = write_enable;

        busy     = (q.size() != 0);
        hs       = busy ? done_idx(q[0].kind) : -1;
        done_now = busy && (step_cyc == lat);
        rst      = rst_in;
        m_read   = 1'($urandom);
        if (start) begin
            hsel = 1'b1; addr_match = 1'b1; m_write = 1'b1; key_mode = km;
        end else if (busy && noise) begin
            hsel = 1'($urandom); addr_match = 1'($urandom);
            m_write = 1'($urandom); key_mode = 2'($urandom);
        end else begin
            hsel = 1'($urandom); addr_match = 1'($urandom);
            m_write = 1'b0; key_mode = 2'($urandom);
        end
        dn = '0;
        for (int i = 0; i < 7; i++)
            if (noise && i != hs && $urandom_range(3, 0) == 0) dn[i] = 1'b1;
        if (done_now) dn[hs] = 1'b1;
        data_ready = dn[0]; keyexp_finished = dn[1]; sbytes_finished = dn[2];
        srows_finished = dn[3]; mcol_finished = dn[4]; around_finished = dn[5];
        write_finished = dn[6];

        @(posedge clk);
        if (rst_in) begin
            q.delete(); m_err = 1'b0; step_cyc = 0;
        end else if (busy) begin
            if (done_now) begin
                void'(q.pop_front());
                step_cyc = 0;
                lat = pick_lat();
            end else begin
                step_cyc++;
                if (step_cyc == TMO) begin
                    q.delete(); m_err = 1'b1; step_cyc = 0;
                end
            end
        end else if (start) begin
            if (km == 2'b11) begin
                m_err = 1'b1;
            end else begin
                m_err = 1'b0;
                build_job(nr_of(int'(km)));
                step_cyc = 0;
                lat = pick_lat();
            end
        end
    endtask

    task automatic finish_job();
        int n;
        n = 0;
        while (q.size() != 0 && n < 6000) begin
            cyc(1'b0, 1'b0, 2'b00);
            n++;
        end
        if (q.size() != 0) begin
            errors++;
            $display("FAIL job_bound: got %0d cycles expected completion", n);
            q.delete();
        end
    endtask

    task automatic run_to(input int kind, input int rnd);
        int n;
        n = 0;
        while (!(q.size() != 0 && q[0].kind == kind && (rnd < 0 || q[0].rnd == rnd))
               && n < 3000) begin
            cyc(1'b0, 1'b0, 2'b00);
            n++;
        end
        if (n >= 3000) begin
            errors++;
            $display("FAIL reach_step: got no step %0d expected it within bound", kind);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'b00);
    endtask

    initial begin
        checks = 0; errors = 0; cyc_no = 0;
        m_err = 1'b0; step_cyc = 0; lat = 0; lat_max = 3; force_lat = -1; noise = 1'b1;
        p_mc = 0; p_ar = 0; p_ke = 0; p_rd = 0; p_wr = 0;
        rst = 1'b1; hsel = 0; addr_match = 0; m_write = 0; m_read = 0;
        data_ready = 0; key_mode = 0; keyexp_finished = 0; sbytes_finished = 0;
        srows_finished = 0; mcol_finished = 0; around_finished = 0; write_finished = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_lit("reset_outputs", int'(dut_vec()), int'({1'b1, 8'h00, 1'b0, 4'd0, 8'd0}));

        // AES-128, immediate done strobes
        force_lat = 0; clear_counts();
        cyc(1'b0, 1'b1, 2'b00);
        finish_job();
        idle(2);
        check_lit("aes128_mcol_pulses", cnt_mc, 9 * NB);
        check_lit("aes128_ark_pulses", cnt_ar, 11 * NB);
        check_lit("aes128_keyexp_pulses", cnt_ke, 1);
        check_lit("aes128_busy_cycles", cnt_busy, 2 + NB * 42);
        check_lit("aes128_hready_end", int'(HREADYOUT), 1);

        // AES-256, multi-block, random latency
        force_lat = -1; clear_counts();
        cyc(1'b0, 1'b1, 2'b10);
        finish_job();
        idle(2);
        check_lit("aes256_keyexp_pulses", cnt_ke, 1);
        check_lit("aes256_read_pulses", cnt_rd, NB);
        check_lit("aes256_mcol_pulses", cnt_mc, 13 * NB);
        check_lit("aes256_ark_pulses", cnt_ar, 15 * NB);
        for (int i = 0; i < rd_blk.size(); i++) check_lit("aes256_block_seq", rd_blk[i], i);
        check_lit("aes256_block_end", int'(block_num), 0);

        // illegal key mode, then recovery
        cyc(1'b0, 1'b1, 2'b11);
        #1;
        check_lit("illegal_error", int'({error, HREADYOUT, readk_enable}), 3'b110);
        idle(3);
        cyc(1'b0, 1'b1, 2'b00);
        #1;
        check_lit("recover_readk", int'({error, readk_enable}), 2'b01);
        finish_job();
        idle(2);

        // watchdog: sub bytes withheld
        clear_counts();
        cyc(1'b0, 1'b1, 2'b00);
        run_to(K_SB, 1);
        lat = 100000;
        idle(TMO + 2);
        check_lit("timeout_sb_cycles", cnt_sbh, TMO);
        check_lit("timeout_error", int'(error), 1);

        // watchdog: done on the last allowed cycle wins
        clear_counts();
        cyc(1'b0, 1'b1, 2'b00);
        run_to(K_SB, 1);
        lat = TMO - 1;
        run_to(K_SR, 1);
        check_lit("late_done_sb_cycles", cnt_sbh, TMO);
        #1;
        check_lit("late_done_srows", int'({error, srows_enable}), 2'b01);
        finish_job();
        idle(2);

        // reset during mix columns of round 5
        clear_counts();
        cyc(1'b0, 1'b1, 2'b01);
        run_to(K_MC, 5);
        cyc(1'b1, 1'b0, 2'b00);
        #1;
        check_lit("rst_abort", int'(dut_vec()), int'({1'b1, 8'h00, 1'b0, 4'd0, 8'd0}));
        idle(4);
        check_lit("rst_no_write", cnt_wr, 0);

        // randomized jobs
        for (int j = 0; j < 12; j++) begin
            logic [1:0] km;
            km = ($urandom_range(7, 0) == 0) ? 2'b11 : 2'($urandom_range(2, 0));
            cyc(1'b0, 1'b1, km);
            finish_job();
            idle(int'($urandom_range(3, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
